bus_ctrl: RTL and testbench
===========================

BUS_CTRL -- requirements
Module: bus_ctrl

Interface
REQ-001 Parameter: TIMEOUT, default 64, number of ACCESS cycles without ack before abort.
REQ-002 Parameter: NTGT, default 8, number of bus targets (index 7 = "others"/unmapped).
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 cpu_req  input  1  CPU memory access request, held stable while cpu_stall=1.
REQ-006 cpu_we  input  1  1 = write, 0 = read.
REQ-007 cpu_addr  input  32  byte address.
REQ-008 cpu_wdata  input  32  write data.
REQ-009 cpu_be  input  4  byte enables.
REQ-010 tgt_sel  input  NTGT  one-hot target select from address decoder (TEXTS, DATAS, BIOS, textRAM, graphRAM, DRAM, dmaRAM, others).
REQ-011 cpu_stall  output  1  pipeline hold.
REQ-012 cpu_done  output  1  one-cycle completion strobe.
REQ-013 cpu_err  output  1  one-cycle bus-error strobe.
REQ-014 cpu_rdata  output  32  read data, valid when cpu_done=1 and latched read.
REQ-015 bus_cs  output  NTGT  one-hot target chip select.
REQ-016 bus_addr / bus_wdata  output  32 / 32  registered address and write data.
REQ-017 bus_we / bus_be  output  1 / 4  registered write strobe, byte enables.
REQ-018 bus_ack  input  NTGT  per-target completion.
REQ-019 bus_rdata  input  32*NTGT  flattened per-target read data, target i at [32i+31:32i].

Function
REQ-020 States: IDLE, ACCESS, DONE, ERR.
REQ-021 IDLE: cpu_req=1 -> latch addr/wdata/we/be/tgt_sel; next ACCESS if valid, else ERR.
REQ-022 Invalid: tgt_sel not exactly one-hot, tgt_sel[7]=1, or cpu_be=0.
REQ-023 cpu_stall = (IDLE & cpu_req) | ACCESS; combinational; 0 in DONE and ERR.
REQ-024 ACCESS: bus_cs = latched select; bus_addr/wdata/we/be from latches.
REQ-025 ACCESS: bus_ack bit of selected target = 1 -> capture that target's bus_rdata (reads), go DONE; acks of unselected targets ignored.
REQ-026 Minimum latency: request seen cycle N, ack in cycle N+1, cpu_done in N+2.
REQ-027 Timeout counter clears on IDLE->ACCESS, increments each ACCESS cycle; TIMEOUT-1 reached without ack -> ERR.
REQ-028 Ack in the same cycle the counter hits TIMEOUT-1: ack wins, go DONE.
REQ-029 DONE: cpu_done=1 one cycle, bus_cs=0, next IDLE.
REQ-030 ERR: cpu_err=1 one cycle, bus_cs=0, cpu_rdata=0, next IDLE.
REQ-031 New requests sampled only in IDLE; cpu_req during DONE/ERR ignored.
REQ-032 cpu_rdata holds last captured value until next read completion; writes leave it unchanged.
REQ-033 bus_cs never has more than one bit set.

Reset
REQ-034 rst_n=0: state IDLE; counter 0; bus_cs, bus_we, bus_be, bus_addr, bus_wdata, cpu_rdata = 0; cpu_done, cpu_err = 0.
REQ-035 Reset mid-ACCESS drops bus_cs same cycle (asynchronous); the pending transaction is discarded, no done/err.

Structure
REQ-036 Shared package bus_defs holds target index constants, state encoding, TIMEOUT default.
REQ-037 Timeout counter is sub-module bus_timer (clear, enable, expire output).

Verification
REQ-038 Read DATAS (tgt_sel=8'b0000_0010), ack next cycle with 0xDEADBEEF -> cpu_done cycle N+2, cpu_rdata=0xDEADBEEF, stall 2 cycles.
REQ-039 Write DRAM addr 0x2000_0000, wdata 0x1234_5678, be=4'b0011, ack after 5 cycles -> bus_cs[5]=1 for 5 cycles, bus_be=0011, done, cpu_rdata unchanged.
REQ-040 tgt_sel=8'b1000_0000 -> ERR next cycle, cpu_err=1, bus_cs never asserted.
REQ-041 graphRAM read, no ack -> after 64 ACCESS cycles cpu_err=1, bus_cs=0; ack on cycle 64 -> cpu_done instead.
REQ-042 tgt_sel=8'b0000_0011 or cpu_be=0 -> cpu_err; ack on unselected target during ACCESS -> no completion.
REQ-043 rst_n low at ACCESS cycle 3 -> bus_cs=0 immediately, no cpu_done/cpu_err after release, next request serviced normally.

Source files
------------

// File: rtl/bus_defs.sv
// Shared definitions for the CPU-to-target bus controller: target indices,
// FSM state encoding and default parameters.
package bus_defs;

   localparam int NTGT_DEF    = 8;
   localparam int TIMEOUT_DEF = 64;

   localparam int TGT_TEXTS    = 0;
   localparam int TGT_DATAS    = 1;
   localparam int TGT_BIOS     = 2;
   localparam int TGT_TEXTRAM  = 3;
   localparam int TGT_GRAPHRAM = 4;
   localparam int TGT_DRAM     = 5;
   localparam int TGT_DMARAM   = 6;
   localparam int TGT_OTHERS   = 7;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2,
      ST_ERR    = 2'd3
   } state_t;

endpackage

// File: rtl/bus_timer.sv
// ACCESS-phase watchdog: counts enabled cycles and flags the last allowed one.
module bus_timer #(
   parameter int TIMEOUT = 64
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [CW-1:0] count;

   // Saturates on the final cycle so a stalled controller cannot wrap back to 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && !expire) begin
         count <= count + 1'b1;
      end
   end

   assign expire = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/bus_ctrl.sv
// Single-outstanding CPU bus controller: latches a request, drives one target,
// waits for its ack (bounded by a timeout) and reports done or bus error.
module bus_ctrl
   import bus_defs::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int NTGT    = NTGT_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cpu_req,
   input  logic                 cpu_we,
   input  logic [31:0]          cpu_addr,
   input  logic [31:0]          cpu_wdata,
   input  logic [3:0]           cpu_be,
   input  logic [NTGT-1:0]      tgt_sel,
   output logic                 cpu_stall,
   output logic                 cpu_done,
   output logic                 cpu_err,
   output logic [31:0]          cpu_rdata,
   output logic [NTGT-1:0]      bus_cs,
   output logic [31:0]          bus_addr,
   output logic [31:0]          bus_wdata,
   output logic                 bus_we,
   output logic [3:0]           bus_be,
   input  logic [NTGT-1:0]      bus_ack,
   input  logic [32*NTGT-1:0]   bus_rdata,
   output state_t               dbg_state
);

   state_t          state_q, state_d;
   logic [NTGT-1:0] sel_q;
   logic [31:0]     addr_q, wdata_q, rdata_q, sel_rdata;
   logic            we_q;
   logic [3:0]      be_q;
   logic            req_valid, ack_hit, timer_clear, timer_en, timer_expire;

   // The last target index is the unmapped "others" decode.
   assign req_valid = $onehot(tgt_sel) && !tgt_sel[NTGT-1] && (cpu_be != 4'b0000);
   assign ack_hit   = |(bus_ack & sel_q);

   always_comb begin
      sel_rdata = '0;
      for (int i = 0; i < NTGT; i++) begin
         if (sel_q[i]) sel_rdata = sel_rdata | bus_rdata[32*i +: 32];
      end
   end

   bus_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (timer_clear),
      .enable (timer_en),
      .expire (timer_expire)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Ack is checked before expiry so a last-cycle ack still completes.
   always_comb begin
      state_d     = state_q;
      cpu_stall   = 1'b0;
      cpu_done    = 1'b0;
      cpu_err     = 1'b0;
      bus_cs      = '0;
      timer_clear = 1'b0;
      timer_en    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            timer_clear = 1'b1;
            if (cpu_req) begin
               cpu_stall = 1'b1;
               state_d   = req_valid ? ST_ACCESS : ST_ERR;
            end
         end
         ST_ACCESS: begin
            cpu_stall = 1'b1;
            bus_cs    = sel_q;
            timer_en  = 1'b1;
            if (ack_hit)           state_d = ST_DONE;
            else if (timer_expire) state_d = ST_ERR;
         end
         ST_DONE: begin
            cpu_done = 1'b1;
            state_d  = ST_IDLE;
         end
         ST_ERR: begin
            cpu_err = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         be_q    <= '0;
      end else if (state_q == ST_IDLE && cpu_req) begin
         sel_q   <= tgt_sel;
         addr_q  <= cpu_addr;
         wdata_q <= cpu_wdata;
         we_q    <= cpu_we;
         be_q    <= cpu_be;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
      end else if (state_q == ST_ACCESS && ack_hit && !we_q) begin
         rdata_q <= sel_rdata;
      end
   end

   assign cpu_rdata = (state_q == ST_ERR) ? 32'h0 : rdata_q;
   assign bus_addr  = addr_q;
   assign bus_wdata = wdata_q;
   assign bus_we    = we_q;
   assign bus_be    = be_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_bus_ctrl.sv
// Randomized and directed bench for bus_ctrl, checked against a transaction-level
// model of completion cycle, stall/select duration and read-data return.
module tb_bus_ctrl;

   localparam int NTGT    = 8;
   localparam int TIMEOUT = 64;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                cpu_req, cpu_we;
   logic [31:0]         cpu_addr, cpu_wdata;
   logic [3:0]          cpu_be;
   logic [NTGT-1:0]     tgt_sel;
   logic                cpu_stall, cpu_done, cpu_err;
   logic [31:0]         cpu_rdata;
   logic [NTGT-1:0]     bus_cs;
   logic [31:0]         bus_addr, bus_wdata;
   logic                bus_we;
   logic [3:0]          bus_be;
   logic [NTGT-1:0]     bus_ack;
   logic [32*NTGT-1:0]  bus_rdata;
   bus_defs::state_t    dbg_state;

   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] model_rdata;
   logic [31:0] exp_q[$];

   bus_ctrl #(.TIMEOUT(TIMEOUT), .NTGT(NTGT)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_be    (cpu_be),
      .tgt_sel   (tgt_sel),
      .cpu_stall (cpu_stall),
      .cpu_done  (cpu_done),
      .cpu_err   (cpu_err),
      .cpu_rdata (cpu_rdata),
      .bus_cs    (bus_cs),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_we    (bus_we),
      .bus_be    (bus_be),
      .bus_ack   (bus_ack),
      .bus_rdata (bus_rdata),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ---------------- driver + model ----------------
   task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input logic [7:0] sel, input int ack_dly,
                          input logic [31:0] ack_data, input bit noise);
      bit          valid, exp_err;
      int          exp_end, exp_cs, end_cyc, stalls, cs_cnt;
      logic [31:0] exp_rd;
      // Model: invalid requests error next cycle; valid ones complete on the
      // ack cycle, or error after TIMEOUT access cycles without one.
      valid = ($countones(sel) == 1) && !sel[7] && (be != 4'b0000);
      if (!valid) begin
         exp_end = 1; exp_err = 1'b1; exp_cs = 0;
      end else if (ack_dly <= TIMEOUT) begin
         exp_end = 1 + ack_dly; exp_err = 1'b0; exp_cs = ack_dly;
      end else begin
         exp_end = 1 + TIMEOUT; exp_err = 1'b1; exp_cs = TIMEOUT;
      end
      exp_rd = exp_err ? 32'h0 : (we ? model_rdata : ack_data);
      exp_q.push_back(exp_rd);
      if (!exp_err && !we) model_rdata = ack_data;

      @(posedge clk); #1;
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
      cpu_be = be; tgt_sel = sel;
      end_cyc = -1; stalls = 0; cs_cnt = 0;
      for (int cyc = 0; cyc < TIMEOUT + 8; cyc++) begin
         if (cyc > 0) begin @(posedge clk); #1; end
         for (int i = 0; i < NTGT; i++) bus_rdata[32*i +: 32] = $urandom;
         bus_ack = noise ? (8'($urandom) & ~sel) : 8'h00;
         if (cyc == ack_dly) begin
            bus_ack = bus_ack | sel;
            for (int i = 0; i < NTGT; i++) if (sel[i]) bus_rdata[32*i +: 32] = ack_data;
         end
         @(negedge clk);
         if (cpu_stall) stalls++;
         check("cs_onehot", 32'($countones(bus_cs) <= 1), 32'd1);
         if (bus_cs != '0) begin
            cs_cnt++;
            check("bus_cs", 32'(bus_cs), 32'(sel));
            check("bus_addr", bus_addr, addr);
            check("bus_wdata", bus_wdata, wdata);
            check("bus_we_be", {27'd0, bus_we, bus_be}, {27'd0, we, be});
         end
         if (cpu_done || cpu_err) begin
            end_cyc = cyc;
            check("done_err", {30'd0, cpu_done, cpu_err}, {30'd0, !exp_err, exp_err});
            check("cpu_rdata", cpu_rdata, exp_q.pop_front());
            break;
         end
      end
      check("end_cycle", 32'(end_cyc), 32'(exp_end));
      check("stall_cycles", 32'(stalls), 32'(exp_end));
      check("cs_cycles", 32'(cs_cnt), 32'(exp_cs));
      // cpu_req was still high during the done/err cycle; it must not start a new access.
      @(posedge clk); #1;
      cpu_req = 1'b0; bus_ack = '0;
      @(negedge clk);
      check("post_idle", {29'd0, cpu_stall, cpu_done, cpu_err}, 32'd0);
      check("rdata_hold", cpu_rdata, model_rdata);
   endtask

   task automatic reset_mid_access();
      @(posedge clk); #1;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h3000_0100; cpu_wdata = 32'h0;
      cpu_be = 4'hF; tgt_sel = 8'b0001_0000; bus_ack = '0;
      for (int c = 1; c <= 3; c++) begin @(posedge clk); #1; end
      @(negedge clk);
      check("pre_rst_cs", 32'(bus_cs), 32'h10);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_cs_drop", 32'(bus_cs), 32'd0);
      check("rst_done_err", {30'd0, cpu_done, cpu_err}, 32'd0);
      check("rst_regs", {bus_addr ^ bus_wdata, 27'd0, bus_we, bus_be}, 64'd0);
      check("rst_rdata", cpu_rdata, 32'd0);
      model_rdata = 32'h0;
      cpu_req = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("after_rst_quiet", {29'd0, cpu_done, cpu_err, (bus_cs != '0)}, 32'd0);
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [7:0]  sel;
      logic [3:0]  be;
      int          r, dly;
      rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      cpu_be = '0; tgt_sel = '0; bus_ack = '0; bus_rdata = '0;
      model_rdata = 32'h0;
      repeat (3) @(negedge clk);
      check("reset_outs", {26'd0, cpu_stall, cpu_done, cpu_err, (bus_cs != '0), bus_we, (bus_be != 0)}, 32'd0);
      check("reset_addr", bus_addr, 32'd0);
      check("reset_wdata", bus_wdata, 32'd0);
      check("reset_rdata", cpu_rdata, 32'd0);
      rst_n = 1'b1;

      // Directed cases
      run_txn(1'b0, 32'h1000_0040, 32'h0, 4'hF, 8'b0000_0010, 1, 32'hDEAD_BEEF, 1'b0);
      run_txn(1'b1, 32'h2000_0000, 32'h1234_5678, 4'b0011, 8'b0010_0000, 5, 32'hAAAA_5555, 1'b0);
      run_txn(1'b0, 32'h7000_0000, 32'h0, 4'hF, 8'b1000_0000, 1, 32'h1111_1111, 1'b0);
      run_txn(1'b0, 32'h4000_0010, 32'h0, 4'hF, 8'b0001_0000, TIMEOUT + 1, 32'h2222_2222, 1'b0);
      run_txn(1'b0, 32'h4000_0020, 32'h0, 4'hF, 8'b0001_0000, TIMEOUT, 32'h3333_3333, 1'b0);
      run_txn(1'b0, 32'h0000_0000, 32'h0, 4'hF, 8'b0000_0011, 1, 32'h4444_4444, 1'b0);
      run_txn(1'b1, 32'h0000_0004, 32'h5, 4'h0, 8'b0000_0100, 1, 32'h5555_5555, 1'b0);
      run_txn(1'b0, 32'h0000_0008, 32'h0, 4'hC, 8'b0000_1000, 7, 32'h6666_6666, 1'b1);
      run_txn(1'b0, 32'h0000_000C, 32'h0, 4'hF, 8'b0000_0000, 1, 32'h7777_7777, 1'b0);

      reset_mid_access();
      run_txn(1'b0, 32'h1000_0080, 32'h0, 4'hF, 8'b0000_0001, 2, 32'hCAFE_F00D, 1'b0);

      // Randomized traffic
      for (int t = 0; t < 40; t++) begin
         r = $urandom_range(0, 9);
         if (r < 7)       sel = 8'd1 << r;
         else if (r == 7) sel = 8'h80;
         else             sel = 8'($urandom);
         be = ($urandom_range(0, 9) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
         r = $urandom_range(0, 19);
         if (r == 0)      dly = TIMEOUT;
         else if (r == 1) dly = TIMEOUT + 1;
         else             dly = $urandom_range(1, 8);
         run_txn(1'($urandom), $urandom, $urandom, be, sel, dly, $urandom, 1'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
